// File: rtl/amns_job_sequencer.sv
// rtl/amns_job_sequencer.sv - batch job sequencer between the AMNS multiplier core and the BRAM master port
module amns_job_sequencer #(
    parameter int unsigned DESC_BASE   = 0,
    parameter int unsigned STATUS_BASE = 64,
    parameter int unsigned MAX_JOBS    = 16
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        done_o,
    output logic        busy_o,
    output logic        error_o,
    output logic [7:0]  jobs_done_o,
    output logic        core_start_o,
    input  logic        core_done_i,
    input  logic [31:0] core_addr_i,
    input  logic [16:0] core_din_i,
    input  logic        core_we_i,
    input  logic        core_en_i,
    output logic [16:0] core_dout_o,
    output logic [31:0] BRAM_addr_o,
    output logic [16:0] BRAM_din_o,
    output logic        BRAM_we_o,
    output logic        BRAM_en_o,
    input  logic [16:0] BRAM_dout_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_FWAIT  = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_STATUS = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [7:0]  LAST_IDX = 8'(MAX_JOBS - 1);
    localparam logic [31:0] DESC_A   = 32'(DESC_BASE);
    localparam logic [31:0] STATUS_A = 32'(STATUS_BASE);

    logic [2:0]  r_state;
    logic [7:0]  r_idx;
    logic [15:0] r_base;
    logic        r_last;
    logic [15:0] r_cnt;
    logic [7:0]  r_jobs_done;
    logic        r_error;

    logic        w_grant;
    logic [31:0] w_addr;
    logic [16:0] w_din;
    logic        w_we;
    logic        w_en;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_idx       <= 8'd0;
            r_base      <= 16'd0;
            r_last      <= 1'b0;
            r_cnt       <= 16'd0;
            r_jobs_done <= 8'd0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_idx       <= 8'd0;
                        r_jobs_done <= 8'd0;
                        r_error     <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_FWAIT;
                S_FWAIT: begin
                    r_base  <= BRAM_dout_i[15:0];
                    r_last  <= BRAM_dout_i[16];
                    r_state <= S_START;
                end
                S_START: begin
                    r_cnt   <= 16'd0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // The cycle that samples core_done is not counted.
                    if (core_done_i) begin
                        r_state <= S_STATUS;
                    end else if (r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_STATUS: begin
                    r_jobs_done <= r_jobs_done + 8'd1;
                    r_state     <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_last) begin
                        r_state <= S_DONE;
                    end else if (r_idx == LAST_IDX) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_grant = (r_state == S_START) || (r_state == S_RUN);

    // Core requests outside the grant window are dropped, never queued.
    always_comb begin
        w_addr = 32'd0;
        w_din  = 17'd0;
        w_we   = 1'b0;
        w_en   = 1'b0;
        if (w_grant) begin
            w_addr = core_addr_i + {16'd0, r_base};
            w_din  = core_din_i;
            w_we   = core_we_i;
            w_en   = core_en_i;
        end else if (r_state == S_FETCH) begin
            w_addr = DESC_A + {24'd0, r_idx};
            w_en   = 1'b1;
        end else if (r_state == S_STATUS) begin
            w_addr = STATUS_A + {24'd0, r_idx};
            w_din  = {1'b1, r_cnt};
            w_we   = 1'b1;
            w_en   = 1'b1;
        end
    end

    assign BRAM_addr_o  = w_addr;
    assign BRAM_din_o   = w_din;
    assign BRAM_we_o    = w_we;
    assign BRAM_en_o    = w_en;
    assign core_dout_o  = BRAM_dout_i;
    assign core_start_o = (r_state == S_START);
    assign done_o       = (r_state == S_DONE);
    assign busy_o       = (r_state != S_IDLE);
    assign error_o      = r_error;
    assign jobs_done_o  = r_jobs_done;

endmodule

// File: tb/tb_amns_job_sequencer.sv
// tb/tb_amns_job_sequencer.sv - directed scoreboard bench for amns_job_sequencer
module tb_amns_job_sequencer;

    logic        clk = 1'b0;
    logic        reset_i, start_i;
    logic        done_o, busy_o, error_o, core_start_o;
    logic [7:0]  jobs_done_o;
    logic        core_done_i, core_we_i, core_en_i;
    logic [31:0] core_addr_i;
    logic [16:0] core_din_i, core_dout_o;
    logic [31:0] BRAM_addr_o;
    logic [16:0] BRAM_din_o, BRAM_dout_i;
    logic        BRAM_we_o, BRAM_en_o;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int start_cnt = 0;

    int run_len = 10;
    bit core_wr = 1'b0;
    bit rogue = 1'b0;

    logic [16:0] mem [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_a = '0;
    logic [16:0] pl_d = '0;
    logic [48:0] exp_q [$];

    always #5 clk = ~clk;

    amns_job_sequencer #(.DESC_BASE(0), .STATUS_BASE(64), .MAX_JOBS(4)) dut (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .done_o(done_o),
        .busy_o(busy_o), .error_o(error_o), .jobs_done_o(jobs_done_o),
        .core_start_o(core_start_o), .core_done_i(core_done_i),
        .core_addr_i(core_addr_i), .core_din_i(core_din_i), .core_we_i(core_we_i),
        .core_en_i(core_en_i), .core_dout_o(core_dout_o), .BRAM_addr_o(BRAM_addr_o),
        .BRAM_din_o(BRAM_din_o), .BRAM_we_o(BRAM_we_o), .BRAM_en_o(BRAM_en_o),
        .BRAM_dout_i(BRAM_dout_i)
    );

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_a] <= pl_d;
        end else if (BRAM_en_o) begin
            if (BRAM_we_o) mem[BRAM_addr_o[9:0]] <= BRAM_din_o;
            BRAM_dout_i <= mem[BRAM_addr_o[9:0]];
        end
    end

    // Every BRAM write must match the next expected write, in order.
    always @(negedge clk) begin
        logic [48:0] got, want;
        if (done_o) done_cnt++;
        if (core_start_o) start_cnt++;
        if (BRAM_en_o && BRAM_we_o) begin
            got = {BRAM_addr_o, BRAM_din_o};
            if (exp_q.size() > 0) want = exp_q.pop_front();
            else want = 'x;
            checks++;
            assert (got === want) else begin
                failures++;
                $error("FAIL bram_write observed=%0h expected=%0h", got, want);
            end
        end
    end

    // Core model: done asserted run_len cycles after the start pulse.
    always begin
        @(posedge clk); #1;
        if (core_start_o) begin
            core_en_i = 1'b0; core_we_i = 1'b0; core_done_i = 1'b0;
            for (int i = 1; i <= run_len; i++) begin
                @(posedge clk); #1;
                core_en_i   = core_wr && (i == 2);
                core_we_i   = core_wr && (i == 2);
                core_addr_i = 32'd5;
                core_din_i  = 17'h01234;
                core_done_i = (i == run_len);
            end
            @(posedge clk); #1;
        end
        core_done_i = rogue; core_en_i = rogue; core_we_i = rogue;
        core_addr_i = 32'd9; core_din_i = 17'h1abcd;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [16:0] d);
        pl_we = 1'b1; pl_a = 10'(a); pl_d = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic expect_wr(input int a, input logic [16:0] d);
        exp_q.push_back({32'(a), d});
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done_o && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("done_seen", {31'd0, done_o}, 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_error"}, {31'd0, error_o}, 32'd0);
        chk({tag, "_jobs"}, {24'd0, jobs_done_o}, 32'd0);
        chk({tag, "_cstart"}, {31'd0, core_start_o}, 32'd0);
        chk({tag, "_bram_ctl"}, {30'd0, BRAM_en_o, BRAM_we_o}, 32'd0);
        chk({tag, "_bram_addr"}, BRAM_addr_o, 32'd0);
        chk({tag, "_bram_din"}, {15'd0, BRAM_din_o}, 32'd0);
    endtask

    initial begin
        int cyc, d0, s0;
        reset_i = 1'b1; start_i = 1'b0;
        repeat (2) tick();
        chk_idle_outputs("reset");
        reset_i = 1'b0;

        // Single job, done 10 cycles after start.
        load(0, 17'h10100);
        run_len = 10; core_wr = 1'b0; d0 = done_cnt;
        expect_wr(64, 17'h10009);
        pulse_start();
        chk("fetch_busy", {31'd0, busy_o}, 32'd1);
        chk("fetch_bram", {30'd0, BRAM_en_o, BRAM_we_o}, 32'd2);
        chk("fetch_addr", BRAM_addr_o, 32'd0);
        chk("fetch_cstart", {31'd0, core_start_o}, 32'd0);
        tick(); tick();
        chk("cstart_n3", {31'd0, core_start_o}, 32'd1);
        wait_done(100, cyc);
        chk("single_latency", 32'(cyc), 32'd13);
        chk("single_jobs", {24'd0, jobs_done_o}, 32'd1);
        chk("single_error", {31'd0, error_o}, 32'd0);
        tick();
        chk("single_idle", {31'd0, busy_o}, 32'd0);
        chk("single_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("dout_pass", {15'd0, core_dout_o}, {15'd0, BRAM_dout_i});

        // Three jobs with relocated core writes.
        load(0, 17'h00100); load(1, 17'h00200); load(2, 17'h10300);
        run_len = 4; core_wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_wr(32'h105 + k * 32'h100, 17'h01234);
            expect_wr(64 + k, 17'h10003);
        end
        pulse_start();
        wait_done(200, cyc);
        chk("three_jobs", {24'd0, jobs_done_o}, 32'd3);
        chk("three_error", {31'd0, error_o}, 32'd0);
        chk("three_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Missing LAST hits the 4-job cap.
        load(3, 17'h00000); load(4, 17'h10000);
        load(2, 17'h00300);
        run_len = 3; core_wr = 1'b0; s0 = start_cnt; d0 = done_cnt;
        for (int k = 0; k < 4; k++) expect_wr(64 + k, 17'h10002);
        pulse_start();
        wait_done(300, cyc);
        chk("cap_error", {31'd0, error_o}, 32'd1);
        chk("cap_jobs", {24'd0, jobs_done_o}, 32'd4);
        tick();
        chk("cap_core_starts", 32'(start_cnt - s0), 32'd4);
        chk("cap_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("cap_error_sticky", {31'd0, error_o}, 32'd1);

        // LAST on job MAX_JOBS-1 completes normally and clears the error.
        load(3, 17'h10000);
        for (int k = 0; k < 4; k++) expect_wr(64 + k, 17'h10002);
        pulse_start();
        chk("error_cleared", {31'd0, error_o}, 32'd0);
        wait_done(300, cyc);
        chk("lastcap_error", {31'd0, error_o}, 32'd0);
        chk("lastcap_jobs", {24'd0, jobs_done_o}, 32'd4);
        tick();

        // Isolation: stray core writes/done and start pulses while busy.
        load(0, 17'h10100);
        rogue = 1'b1; run_len = 6; d0 = done_cnt;
        expect_wr(64, 17'h10005);
        tick(); tick();
        pulse_start();
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("iso_cstart", {31'd0, core_start_o}, 32'd1);
        wait_done(100, cyc);
        chk("iso_latency", 32'(cyc), 32'd9);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("iso_no_restart", {31'd0, busy_o}, 32'd0);
        repeat (3) tick();
        chk("iso_still_idle", {31'd0, busy_o}, 32'd0);
        chk("iso_jobs", {24'd0, jobs_done_o}, 32'd1);
        chk("iso_done_pulses", 32'(done_cnt - d0), 32'd1);
        rogue = 1'b0;
        tick(); tick();

        // Counter saturation.
        run_len = 70000;
        expect_wr(64, 17'h1FFFF);
        pulse_start();
        wait_done(70100, cyc);
        chk("sat_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Reset during RUN of job 2.
        load(0, 17'h00100); load(1, 17'h00200); load(2, 17'h10300);
        run_len = 20; core_wr = 1'b1; s0 = start_cnt; d0 = done_cnt;
        expect_wr(32'h105, 17'h01234);
        expect_wr(64, 17'h10013);
        expect_wr(32'h205, 17'h01234);
        pulse_start();
        cyc = 0;
        while (start_cnt != s0 + 2 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("rst_job2_started", 32'(start_cnt - s0), 32'd2);
        repeat (3) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk_idle_outputs("midreset");
        repeat (30) tick();
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("rst_idle", {31'd0, busy_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/amns_job_sequencer.md
# amns_job_sequencer

Batch controller placed between the AMNS multiplier core and the block-level BRAM master port. It fetches a list of job descriptors from BRAM and, for each descriptor, relocates the core's BRAM accesses to the job's operand block. It then pulses the core's start, times the run, and writes a per-job status word back to BRAM. The processor launches a whole batch with one `start_i` and polls a single `done_o`, instead of reloading operands one multiplication at a time.

## Interface
- `DESC_BASE`, default 0: word address of descriptor 0; descriptor k is at `DESC_BASE + k`.
- `STATUS_BASE`, default 64: word address of status word for job k, at `STATUS_BASE + k`.
- `MAX_JOBS`, default 16: hard cap on jobs per batch, in the range 2..256.

- `clock_i`, in, 1: single clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: batch launch; sampled only in IDLE.
- `done_o`, out, 1: one-cycle pulse at batch end.
- `busy_o`, out, 1: high in every state except IDLE.
- `error_o`, out, 1: sticky flag meaning the cap was reached without a last flag; cleared on the next accepted start.
- `jobs_done_o`, out, 8: count of jobs whose status word has been written in this batch.
- `core_start_o`, out, 1: one-cycle start pulse to the core.
- `core_done_i`, in, 1: core completion.
- `core_addr_i`, in, 32: core BRAM word address, local to the job.
- `core_din_i`, in, 17: core write data.
- `core_we_i`, in, 1: core write enable.
- `core_en_i`, in, 1: core chip enable.
- `core_dout_o`, out, 17: BRAM read data to the core; always equal to `BRAM_dout_i`.
- `BRAM_addr_o`, out, 32: BRAM word address. The top wrapper performs the byte shift.
- `BRAM_din_o`, out, 17: BRAM write data.
- `BRAM_we_o`, out, 1: BRAM write enable.
- `BRAM_en_o`, out, 1: BRAM chip enable.
- `BRAM_dout_i`, in, 17: BRAM read data, with 1-cycle read latency.

## Operation
- Descriptor word format:
  - bit 16 = LAST.
  - bits [15:0] = BASE, the operand-block word address.
- States: IDLE, FETCH, FWAIT, START, RUN, STATUS, NEXT, DONE.
- IDLE:
  - On `start_i`: clear index, `jobs_done_o` and `error_o`, then go to FETCH.
- FETCH:
  - Drive `BRAM_en_o=1`, `BRAM_we_o=0`, `BRAM_addr_o=DESC_BASE+idx`.
  - Go to FWAIT.
- FWAIT:
  - Latch `BRAM_dout_i` into BASE and LAST registers.
  - Go to START.
- START:
  - Drive `core_start_o=1`.
  - Clear the cycle counter.
  - Grant the BRAM port to the core.
  - Go to RUN.
- RUN:
  - Grant held.
  - Counter increments each cycle, saturating at 16'hFFFF.
  - On `core_done_i=1`, go to STATUS.
- Grant, active in START and RUN:
  - `BRAM_addr_o = core_addr_i + BASE` (zero-extended, modulo 2^32).
  - `BRAM_din_o = core_din_i`, `BRAM_we_o = core_we_i`, `BRAM_en_o = core_en_i`.
- STATUS:
  - Drive `BRAM_en_o=1`, `BRAM_we_o=1`, `BRAM_addr_o=STATUS_BASE+idx`.
  - Drive `BRAM_din_o = {1'b1, counter}`.
  - Increment `jobs_done_o`.
  - Go to NEXT.
- NEXT:
  - If LAST: go to DONE.
  - Else if `idx == MAX_JOBS-1`: set `error_o`, go to DONE.
  - Else: increment idx, go to FETCH.
- DONE:
  - Drive `done_o=1`.
  - Go to IDLE.
- Outside the grant, STATUS and FETCH, all BRAM outputs are 0. Core `we`/`en` requests are dropped, not queued.
- `start_i` is ignored while busy.
- `core_done_i` is ignored outside RUN.

## Timing
- Reset values:
  - State IDLE; all outputs 0.
  - BASE, LAST, idx and counter are all 0.
- Reset mid-batch returns to IDLE on the next edge with no status write. No `done_o` pulse is issued.
- `start_i` high at edge n:
  - FETCH at n+1.
  - `core_start_o` high during cycle n+3.
- Status write:
  - Occurs in the cycle after `core_done_i` is sampled in RUN.
  - The counter value is the number of RUN cycles before `core_done_i` was sampled.
  - Example: done on the first RUN cycle gives counter 0.
- Per-job overhead beyond the core run is 5 cycles: FETCH, FWAIT, START, STATUS, NEXT.
- `done_o` fires 2 cycles after the final status write.
- `core_done_i` coinciding with saturation: write 16'hFFFF.
- LAST set on job `MAX_JOBS-1`: normal completion, `error_o` stays 0.

## Test plan
- Single job:
  - Stimulus: `DESC_BASE` word = 17'h1_0100; core model asserts done 10 cycles after start.
  - Response: status word at 64 = 17'h1_0009.
  - Response: `jobs_done_o`=1, `done_o` pulse, `error_o`=0.
- Three jobs:
  - Stimulus: BASEs 0x100, 0x200, 0x300, LAST on the third.
  - Response: core address 5 appears on BRAM as 0x105, then 0x205, then 0x305.
  - Response: status words at 64, 65, 66; `jobs_done_o`=3.
- Missing LAST with `MAX_JOBS`=4:
  - Response: exactly 4 jobs run, `error_o`=1, `done_o` pulses.
  - Response: next `start_i` clears `error_o`.
- Saturation:
  - Stimulus: core done after 70000 cycles.
  - Response: status word = 17'h1_FFFF.
- Isolation:
  - Stimulus: core asserts `we` during FETCH/STATUS; `start_i` and `core_done_i` pulsed in non-accepting states.
  - Response: BRAM sees no core write; no state change.
- Reset in RUN of job 2:
  - Response: IDLE next cycle, all outputs 0, no status write, no `done_o`.
